// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the multi-channel APB PWM controller: register
// offsets, per-channel layout, the decoded-register enum and the per-channel
// write-strobe bundle.
package apb_pwm_pkg;

    // Global registers
    localparam logic [11:0] OFF_CTRL     = 12'h000;
    localparam logic [11:0] OFF_INT_STAT = 12'h004;
    localparam logic [11:0] OFF_INT_EN   = 12'h008;

    // Per-channel register block: CH_BASE + CH_STRIDE*n
    localparam logic [11:0] CH_BASE   = 12'h020;
    localparam logic [11:0] CH_STRIDE = 12'h010;

    // Word index inside a channel block (paddr[3:2])
    localparam logic [1:0] CH_CFG    = 2'd0;
    localparam logic [1:0] CH_PERIOD = 2'd1;
    localparam logic [1:0] CH_DUTY   = 2'd2;
    localparam logic [1:0] CH_CNT    = 2'd3;

    localparam int CFG_POL_BIT = 0;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_INT_STAT,
        REG_INT_EN,
        REG_CFG,
        REG_PERIOD,
        REG_DUTY,
        REG_CNT,
        REG_NONE
    } reg_sel_t;

    // Write strobes into one channel
    typedef struct packed {
        logic cfg;
        logic period;
        logic duty;
    } ch_we_t;

    // Channel number addressed by a channel-space offset (off >= CH_BASE).
    // Out-of-range results are rejected by the caller.
    function automatic logic [7:0] ch_index(input logic [11:0] off);
        logic [11:0] rel;
        rel = (off - CH_BASE) / CH_STRIDE;
        return rel[7:0];
    endfunction

endpackage

// File: rtl/apb_pwm_channel.sv
// One PWM channel: pending and active PERIOD/DUTY, polarity, free-running
// counter, registered output and period-end (wrap) pulse.
// Ports:
//   pclk, presetn  clock, synchronous active-low reset
//   en             channel enable (CTRL bit)
//   we, wdata      register write strobes and write data (already truncated)
//   pol            CFG.POL
//   period, duty   pending values, as read back over APB
//   cnt            live counter
//   pwm            registered PWM output
//   wrap           high in the cycle whose edge ends a period
module apb_pwm_channel
    import apb_pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             en,
    input  ch_we_t           we,
    input  logic [CNT_W-1:0] wdata,
    output logic             pol,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] cnt,
    output logic             pwm,
    output logic             wrap
);

    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act;
    logic             run;
    logic             load;

    assign run  = en && (period_act != '0);
    assign wrap = run && (cnt == period_act - CNT_W'(1));
    // Shadow copies only move at a period boundary, or freely while idle, so
    // a running period never sees a half-applied update.
    assign load = !run || wrap;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pol        <= 1'b0;
            period     <= '0;
            duty       <= '0;
            period_act <= '0;
            duty_act   <= '0;
            cnt        <= '0;
            pwm        <= 1'b0;
        end else begin
            if (we.cfg)    pol    <= wdata[CFG_POL_BIT];
            if (we.period) period <= wdata;
            if (we.duty)   duty   <= wdata;

            if (load) begin
                period_act <= period;
                duty_act   <= duty;
            end

            cnt <= (run && !wrap) ? cnt + CNT_W'(1) : '0;
            // duty_act >= period_act naturally yields constant active
            pwm <= run ? ((cnt < duty_act) ^ pol) : pol;
        end
    end

endmodule

// File: rtl/apb_pwm_multi_ctrl.sv
// APB3 slave PWM controller with NUM_CH channels of CNT_W-bit counters,
// per-channel polarity, shadowed PERIOD/DUTY and a maskable period-end irq.
// Ports:
//   pclk, presetn         clock, synchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata         APB address (bits [11:0] decoded) and write data
//   prdata, pready        read data (0 outside read access phase), always ready
//   pslverr               error in access phase for unmapped / misaligned access
//   pwm_out               PWM pins, bit n = channel n
//   irq                   |(INT_STAT & INT_EN)
module apb_pwm_multi_ctrl
    import apb_pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    logic [11:0]                   off;
    logic [7:0]                    ch_idx;
    reg_sel_t                      sel;
    logic                          access;
    logic                          wr_en;
    logic                          rd_en;
    logic [NUM_CH-1:0]             ctrl;
    logic [NUM_CH-1:0]             int_stat;
    logic [NUM_CH-1:0]             int_en;
    logic [NUM_CH-1:0]             w1c;
    logic [NUM_CH-1:0]             pol;
    logic [NUM_CH-1:0]             wrap;
    logic [NUM_CH-1:0][CNT_W-1:0]  period_pend;
    logic [NUM_CH-1:0][CNT_W-1:0]  duty_pend;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
    ch_we_t                        ch_we [NUM_CH];
    logic [31:0]                   rdata;
    logic                          unused;

    assign off    = paddr[11:0];
    assign unused = ^{paddr[31:12], pwdata};

    // Address decode; anything not matched stays REG_NONE and errors
    always_comb begin
        sel    = REG_NONE;
        ch_idx = ch_index(off);
        if (paddr[1:0] == 2'b00) begin
            if (off == OFF_CTRL)
                sel = REG_CTRL;
            else if (off == OFF_INT_STAT)
                sel = REG_INT_STAT;
            else if (off == OFF_INT_EN)
                sel = REG_INT_EN;
            else if (off >= CH_BASE && 32'(ch_idx) < 32'(NUM_CH)) begin
                case (off[3:2])
                    CH_CFG:    sel = REG_CFG;
                    CH_PERIOD: sel = REG_PERIOD;
                    CH_DUTY:   sel = REG_DUTY;
                    default:   sel = REG_CNT;
                endcase
            end
        end
    end

    assign access  = psel && penable;
    assign wr_en   = access && pwrite && (sel != REG_NONE);
    assign rd_en   = access && !pwrite && (sel != REG_NONE);
    assign pslverr = access && (sel == REG_NONE);
    assign pready  = 1'b1;

    assign w1c = (wr_en && sel == REG_INT_STAT) ? pwdata[NUM_CH-1:0] : '0;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ctrl     <= '0;
            int_en   <= '0;
            int_stat <= '0;
        end else begin
            if (wr_en && sel == REG_CTRL)   ctrl   <= pwdata[NUM_CH-1:0];
            if (wr_en && sel == REG_INT_EN) int_en <= pwdata[NUM_CH-1:0];
            // hardware set takes priority over a same-cycle clear
            int_stat <= (int_stat & ~w1c) | wrap;
        end
    end

    assign irq = |(int_stat & int_en);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit      = wr_en && (ch_idx == 8'(i));
        assign ch_we[i] = '{cfg:    hit && (sel == REG_CFG),
                            period: hit && (sel == REG_PERIOD),
                            duty:   hit && (sel == REG_DUTY)};

        apb_pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .pclk    (pclk),
            .presetn (presetn),
            .en      (ctrl[i]),
            .we      (ch_we[i]),
            .wdata   (pwdata[CNT_W-1:0]),
            .pol     (pol[i]),
            .period  (period_pend[i]),
            .duty    (duty_pend[i]),
            .cnt     (cnt[i]),
            .pwm     (pwm_out[i]),
            .wrap    (wrap[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:     rdata[NUM_CH-1:0] = ctrl;
            REG_INT_STAT: rdata[NUM_CH-1:0] = int_stat;
            REG_INT_EN:   rdata[NUM_CH-1:0] = int_en;
            REG_CFG, REG_PERIOD, REG_DUTY, REG_CNT: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_idx == 8'(i)) begin
                        case (sel)
                            REG_CFG:    rdata[CFG_POL_BIT] = pol[i];
                            REG_PERIOD: rdata[CNT_W-1:0]   = period_pend[i];
                            REG_DUTY:   rdata[CNT_W-1:0]   = duty_pend[i];
                            default:    rdata[CNT_W-1:0]   = cnt[i];
                        endcase
                    end
                end
            end
            default: rdata = '0;
        endcase
    end

    assign prdata = rd_en ? rdata : '0;

endmodule
